// File: rtl/ad9276_pkg.sv
// rtl/ad9276_pkg.sv - shared types and frame geometry for the AD9276 acquisition sequencer
package ad9276_pkg;

    localparam int NCH = 8;
    localparam int DW  = 14;
    localparam int FW  = NCH * DW;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_LOCK,
        ARMED,
        DELAY,
        CAPTURE,
        DONE
    } state_e;

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - 2-FF synchronizer followed by a rising-edge pulse
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic pulse
);

    logic [2:0] sync_q;
    logic [2:0] sync_d;

    always_comb begin
        sync_d = {sync_q[1:0], async_in};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    // sync_q[0] may be metastable; only the second and third stages feed logic.
    assign pulse = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/ad9276_acq_ctrl.sv
// rtl/ad9276_acq_ctrl.sv - lock-gated, triggered frame capture sequencer for the AD9276 deserializer
module ad9276_acq_ctrl
    import ad9276_pkg::*;
#(
    parameter int AW       = 12,
    parameter int DLYW     = 16,
    parameter int LOCK_CYC = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            dco_locked,
    input  logic            frame_stb,
    input  logic [FW-1:0]   din,
    input  logic            start,
    input  logic            soft_trig,
    input  logic            ext_trig,
    input  logic            trig_sel,
    input  logic [DLYW-1:0] cfg_delay,
    input  logic [AW:0]     cfg_nsamp,
    input  logic            abort,
    output logic            wr_en,
    output logic [AW-1:0]   wr_addr,
    output logic [FW-1:0]   wr_data,
    output logic            busy,
    output logic            armed,
    output logic            done,
    output logic            err,
    output logic [AW:0]     frames_written
);

    localparam int LCW = $clog2(LOCK_CYC + 1);

    logic ext_pulse;

    sync_edge_det u_ext_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (ext_trig),
        .pulse    (ext_pulse)
    );

    state_e          state_q, state_d;
    logic [LCW-1:0]  lock_cnt_q, lock_cnt_d;
    logic [DLYW-1:0] delay_q, delay_d;
    logic [AW:0]     nsamp_q, nsamp_d;
    logic            sel_q, sel_d;
    logic [DLYW-1:0] dly_cnt_q, dly_cnt_d;
    logic            wr_en_q, wr_en_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [FW-1:0]   wr_data_q, wr_data_d;
    logic            busy_q, busy_d;
    logic            armed_q, armed_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [AW:0]     fw_q, fw_d;

    logic lock_ok;
    logic trig;
    logic busy_st;
    logic last_write;

    assign lock_ok    = (lock_cnt_q == LCW'(LOCK_CYC));
    assign trig       = sel_q ? ext_pulse : soft_trig;
    assign busy_st    = (state_q != IDLE) && (state_q != DONE);
    assign last_write = wr_en_q && ((fw_q + (AW+1)'(1)) == nsamp_q);

    always_comb begin
        lock_cnt_d = lock_cnt_q;
        if (!dco_locked) begin
            lock_cnt_d = '0;
        end else if (!lock_ok) begin
            lock_cnt_d = lock_cnt_q + LCW'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        delay_d   = delay_q;
        nsamp_d   = nsamp_q;
        sel_d     = sel_q;
        dly_cnt_d = dly_cnt_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = done_q;
        err_d     = err_q;
        fw_d      = fw_q;

        // Address and count advance at the end of the write cycle, so wr_addr
        // shows the slot being written and then the next free slot.
        if (wr_en_q) begin
            wr_addr_d = wr_addr_q + AW'(1);
            fw_d      = fw_q + (AW+1)'(1);
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = WAIT_LOCK;
                    delay_d   = cfg_delay;
                    nsamp_d   = cfg_nsamp;
                    sel_d     = trig_sel;
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                    fw_d      = '0;
                    wr_addr_d = '0;
                end
            end
            WAIT_LOCK: begin
                if (lock_ok) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (trig) begin
                    if (nsamp_q == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else if (delay_q != '0) begin
                        state_d   = DELAY;
                        dly_cnt_d = delay_q;
                    end else begin
                        state_d = CAPTURE;
                    end
                end
            end
            DELAY: begin
                if (frame_stb) begin
                    dly_cnt_d = dly_cnt_q - DLYW'(1);
                    if (dly_cnt_q == DLYW'(1)) begin
                        state_d = CAPTURE;
                    end
                end
            end
            CAPTURE: begin
                if (last_write) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (frame_stb) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = din;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort outranks lock loss; both outrank everything above, including a
        // write that would otherwise be issued this cycle.
        if (busy_st && (abort || (!dco_locked && state_q != WAIT_LOCK))) begin
            state_d = IDLE;
            err_d   = 1'b1;
            done_d  = 1'b0;
            wr_en_d = 1'b0;
        end
    end

    always_comb begin
        busy_d  = (state_d != IDLE) && (state_d != DONE);
        armed_d = (state_d == ARMED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            lock_cnt_q <= '0;
            delay_q    <= '0;
            nsamp_q    <= '0;
            sel_q      <= 1'b0;
            dly_cnt_q  <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            armed_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            fw_q       <= '0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            delay_q    <= delay_d;
            nsamp_q    <= nsamp_d;
            sel_q      <= sel_d;
            dly_cnt_q  <= dly_cnt_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            armed_q    <= armed_d;
            done_q     <= done_d;
            err_q      <= err_d;
            fw_q       <= fw_d;
        end
    end

    assign wr_en          = wr_en_q;
    assign wr_addr        = wr_addr_q;
    assign wr_data        = wr_data_q;
    assign busy           = busy_q;
    assign armed          = armed_q;
    assign done           = done_q;
    assign err            = err_q;
    assign frames_written = fw_q;

endmodule

// File: doc/ad9276_acq_ctrl.md
Name: ad9276_acq_ctrl

Overview:
Acquisition sequencer for the AD9276 8-channel LVDS deserializer. It waits for DCO PLL lock, arms on a software start, and waits for a trigger. After a programmable pre-delay it writes a programmed number of 8-channel sample frames into the capture RAM, then reports done. It runs in the deserializer's DCO clock domain and consumes that block's one-cycle frame strobe and 8x14-bit words.

Parameters:
NCH, 8, number of ADC channels
DW, 14, bits per channel sample
AW, 12, capture RAM address width (max 2^AW frames)
DLYW, 16, trigger-to-capture delay counter width, in frames
LOCK_CYC, 64, clk cycles dco_locked must be continuously high before arming is allowed

Ports:
clk  in  1  DCO-domain clock, same clock as the deserializer
rst  in  1  reset
dco_locked  in  1  PLL lock from deserializer, synchronous to clk
frame_stb  in  1  one-cycle pulse per new frame; din valid in that cycle
din  in  NCH*DW  packed channel words, ch A at LSBs
start  in  1  one-cycle software arm request
soft_trig  in  1  one-cycle software trigger
ext_trig  in  1  asynchronous external trigger, rising-edge active
trig_sel  in  1  0=soft_trig, 1=ext_trig
cfg_delay  in  DLYW  frames skipped after trigger
cfg_nsamp  in  AW+1  frames to capture (0..2^AW)
abort  in  1  one-cycle cancel request
wr_en  out  1  capture RAM write enable
wr_addr  out  AW  capture RAM address
wr_data  out  NCH*DW  capture RAM data
busy  out  1  high in every state except IDLE and DONE
armed  out  1  high in ARMED
done  out  1  level; capture completed
err  out  1  level; lock lost or abort during sequence
frames_written  out  AW+1  count of frames written in the current or last run

Behaviour:
- Reset is rst: synchronous, active-high. All outputs are 0 after reset; the state is IDLE; the lock counter is cleared.
- ext_trig passes through a 2-FF synchronizer, then a rising-edge detector. The resulting trigger pulse lags the pad by 2-3 cycles.
- Lock qualifier: a counter increments while dco_locked=1 and clears when it is 0. lock_ok=1 once the count reaches LOCK_CYC; the counter saturates there.
- States:
  - IDLE: on start go to WAIT_LOCK. On that same edge, latch cfg_delay, cfg_nsamp and trig_sel, and clear done, err, frames_written and wr_addr.
  - WAIT_LOCK: when lock_ok=1, go to ARMED.
  - ARMED: on the selected trigger pulse, go to DELAY if the latched delay is nonzero, else to CAPTURE. Triggers arriving in any other state are ignored; there is no queuing.
  - DELAY: decrement the delay counter on each frame_stb. Go to CAPTURE on the frame_stb where the counter reaches 0. That frame is not written.
  - CAPTURE: on each frame_stb, the next cycle drives wr_en=1, wr_data=din registered, wr_addr=current address. Then the address increments and frames_written increments. This is one-cycle registered latency from frame_stb to the write. After the write of frame number nsamp, go to DONE.
  - DONE: done=1 and busy=0. A start here behaves as in IDLE (re-arm).
- nsamp=0: ARMED goes directly to DONE on the trigger, with no writes.
- nsamp=2^AW: wr_addr wraps to 0 after the last write, and frames_written = 2^AW.
- Lock loss: dco_locked=0 in WAIT_LOCK is not an error; the block keeps waiting. dco_locked=0 in ARMED, DELAY or CAPTURE sets err=1 and returns to IDLE. Any write pending that cycle is suppressed.
- abort: in any busy state, sets err=1 and returns to IDLE next cycle. abort in IDLE or DONE has no effect.
- Simultaneous events: abort has priority over lock loss, which has priority over trigger. A start while busy is ignored.
- A start coincident with abort in a busy state aborts only; it does not re-arm.
- Synchronous reset mid-capture: state returns to IDLE and all outputs clear. RAM contents are undefined.
- wr_en is never high for two consecutive frames' worth of the same address. wr_en is never high outside the write cycle that follows a frame_stb in CAPTURE.

Decomposition:
- Package ad9276_pkg holds:
  - state enum: IDLE, WAIT_LOCK, ARMED, DELAY, CAPTURE, DONE;
  - NCH and DW constants;
  - the packed-frame width NCH*DW.
- Sub-module sync_edge_det: 2-FF synchronizer plus rising-edge pulse, reused for ext_trig.
- Lock counter and FSM stay in the top level.

Test Plan:
- Lock gate: dco_locked low, start issued, then lock high -> armed=1 exactly LOCK_CYC=64 cycles after lock rises; no arming before that.
- Basic capture: delay=3, nsamp=5, soft_trig -> 3 frame_stb skipped, then 5 writes at addr 0..4. Each write's data equals din at its strobe, one cycle after the strobe. done=1 and frames_written=5.
- ext_trig edge: ext_trig held high for 100 cycles while armed -> exactly one trigger, asserted 2-3 cycles after the edge. A second edge during CAPTURE is ignored.
- Boundaries: nsamp=0 -> done on trigger with wr_en never asserted. nsamp=4096 (AW=12) -> 4096 writes, wr_addr wraps to 0, frames_written=4096.
- Fault: drop dco_locked after 2 written frames -> err=1, state IDLE, no further wr_en, frames_written=2. Abort in DELAY -> err=1, no writes.
- Re-arm: start in DONE -> done and err clear, frames_written=0, sequence repeats. A start pulsed during CAPTURE is ignored.
